// File: rtl/persist_high_monitor.sv
// Run-time checker for "m holds high now and on every later cycle"; each low enabled sample is a violation.
// Optional cycle timestamp of the first violation is enabled with `define PERSIST_MON_TIMESTAMP_EN.
module persist_high_monitor #(
  parameter int CNT_W = 16,
  parameter int TS_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             m,
  output logic             fail_pulse,
  output logic             fail_sticky,
  output logic [CNT_W-1:0] fail_count,
  output logic [CNT_W-1:0] run_len,
  output logic [CNT_W-1:0] max_run,
  output logic             armed,
  output logic [TS_W-1:0]  first_fail_ts
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             fail_pulse_q, fail_pulse_d;
  logic             fail_sticky_q, fail_sticky_d;
  logic [CNT_W-1:0] fail_count_q, fail_count_d;
  logic [CNT_W-1:0] run_len_q, run_len_d;
  logic [CNT_W-1:0] max_run_q, max_run_d;
  logic             armed_q, armed_d;
  logic             viol;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    fail_pulse_d  = 1'b0;
    fail_sticky_d = fail_sticky_q;
    fail_count_d  = fail_count_q;
    run_len_d     = run_len_q;
    max_run_d     = max_run_q;
    armed_d       = armed_q;
    viol          = 1'b0;
    if (clr) begin
      fail_sticky_d = 1'b0;
      fail_count_d  = '0;
      run_len_d     = '0;
      max_run_d     = '0;
      armed_d       = 1'b0;
    end else if (en) begin
      armed_d = 1'b1;
      // An X/Z sample fails the equality test and so falls into the violation branch.
      if (m == 1'b1) begin
        if (run_len_q != CNT_MAX) run_len_d = run_len_q + CNT_ONE;
        if (run_len_d > max_run_q) max_run_d = run_len_d;
      end else begin
        viol          = 1'b1;
        fail_pulse_d  = 1'b1;
        fail_sticky_d = 1'b1;
        run_len_d     = '0;
        if (fail_count_q != CNT_MAX) fail_count_d = fail_count_q + CNT_ONE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_pulse_q  <= 1'b0;
      fail_sticky_q <= 1'b0;
      fail_count_q  <= '0;
      run_len_q     <= '0;
      max_run_q     <= '0;
      armed_q       <= 1'b0;
    end else begin
      fail_pulse_q  <= fail_pulse_d;
      fail_sticky_q <= fail_sticky_d;
      fail_count_q  <= fail_count_d;
      run_len_q     <= run_len_d;
      max_run_q     <= max_run_d;
      armed_q       <= armed_d;
    end
  end

  assign fail_pulse  = fail_pulse_q;
  assign fail_sticky = fail_sticky_q;
  assign fail_count  = fail_count_q;
  assign run_len     = run_len_q;
  assign max_run     = max_run_q;
  assign armed       = armed_q;

`ifdef PERSIST_MON_TIMESTAMP_EN
  localparam logic [TS_W-1:0] TS_ONE = TS_W'(1);

  logic [TS_W-1:0] ts_q, ts_d;
  logic [TS_W-1:0] first_ts_q, first_ts_d;

  // Free-running cycle counter; wraps naturally at its top value.
  always_comb begin
    ts_d       = ts_q + TS_ONE;
    first_ts_d = first_ts_q;
    if (clr) begin
      ts_d       = '0;
      first_ts_d = '0;
    end else if (viol && !fail_sticky_q) begin
      first_ts_d = ts_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q       <= '0;
      first_ts_q <= '0;
    end else begin
      ts_q       <= ts_d;
      first_ts_q <= first_ts_d;
    end
  end

  assign first_fail_ts = first_ts_q;
`else
  assign first_fail_ts = '0;
`endif

endmodule

// File: tb/tb_persist_high_monitor.sv
// Scoreboard bench for persist_high_monitor: a 16-bit and a 4-bit instance share stimulus and are
// compared every cycle against a behavioural model, plus hand-computed spot checks.
module tb_persist_high_monitor;

  typedef struct packed {
    logic        pulse;
    logic        sticky;
    logic        armed;
    logic [15:0] fc;
    logic [15:0] rl;
    logic [15:0] mr;
    logic [3:0]  fc4;
    logic [3:0]  rl4;
    logic [3:0]  mr4;
    logic [31:0] ts;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, en, clr, m;

  logic        fail_pulse, fail_sticky, armed;
  logic [15:0] fail_count, run_len, max_run;
  logic [31:0] first_fail_ts;
  logic        fail_pulse4, fail_sticky4, armed4;
  logic [3:0]  fail_count4, run_len4, max_run4;
  logic [31:0] first_fail_ts4;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  // Behavioural model state
  logic        md_pulse, md_sticky, md_armed;
  logic [15:0] md_fc, md_rl, md_mr;
  logic [3:0]  md_fc4, md_rl4, md_mr4;
  logic [31:0] md_ts, md_first;

  always #5 clk = ~clk;

  persist_high_monitor dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .m(m),
    .fail_pulse(fail_pulse), .fail_sticky(fail_sticky), .fail_count(fail_count),
    .run_len(run_len), .max_run(max_run), .armed(armed), .first_fail_ts(first_fail_ts)
  );

  persist_high_monitor #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .m(m),
    .fail_pulse(fail_pulse4), .fail_sticky(fail_sticky4), .fail_count(fail_count4),
    .run_len(run_len4), .max_run(max_run4), .armed(armed4), .first_fail_ts(first_fail_ts4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    md_pulse = 0; md_sticky = 0; md_armed = 0;
    md_fc = 0; md_rl = 0; md_mr = 0;
    md_fc4 = 0; md_rl4 = 0; md_mr4 = 0;
    md_ts = 0; md_first = 0;
  endtask

  // Called at a negedge: drive inputs, predict the post-edge outputs, wait for the next negedge.
  task automatic step(input logic e_in, input logic c_in, input logic m_in);
    exp_t e;
    en = e_in; clr = c_in; m = m_in;
    if (c_in) begin
      model_reset();
    end else begin
      md_pulse = 0;
      if (e_in) begin
        md_armed = 1;
        if (m_in) begin
          if (md_rl != 16'hFFFF) md_rl = md_rl + 16'd1;
          if (md_rl4 != 4'hF) md_rl4 = md_rl4 + 4'd1;
          if (md_rl > md_mr) md_mr = md_rl;
          if (md_rl4 > md_mr4) md_mr4 = md_rl4;
        end else begin
          if (!md_sticky) md_first = md_ts;
          md_pulse = 1; md_sticky = 1;
          md_rl = 0; md_rl4 = 0;
          if (md_fc != 16'hFFFF) md_fc = md_fc + 16'd1;
          if (md_fc4 != 4'hF) md_fc4 = md_fc4 + 4'd1;
        end
      end
      md_ts = md_ts + 32'd1;
    end
    e.pulse = md_pulse; e.sticky = md_sticky; e.armed = md_armed;
    e.fc = md_fc; e.rl = md_rl; e.mr = md_mr;
    e.fc4 = md_fc4; e.rl4 = md_rl4; e.mr4 = md_mr4;
`ifdef PERSIST_MON_TIMESTAMP_EN
    e.ts = md_first;
`else
    e.ts = 32'd0;
`endif
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic steps(input int n, input logic e_in, input logic m_in);
    for (int i = 0; i < n; i++) step(e_in, 1'b0, m_in);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".fail_pulse"}, fail_pulse, 0);
    check({tag, ".fail_sticky"}, fail_sticky, 0);
    check({tag, ".fail_count"}, fail_count, 0);
    check({tag, ".run_len"}, run_len, 0);
    check({tag, ".max_run"}, max_run, 0);
    check({tag, ".armed"}, armed, 0);
    check({tag, ".first_fail_ts"}, first_fail_ts, 0);
    check({tag, ".fail_count4"}, fail_count4, 0);
    check({tag, ".max_run4"}, max_run4, 0);
  endtask

  // Monitor: every cycle the DUT presents a fresh registered output, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("fail_pulse", fail_pulse, e.pulse);
        check("fail_sticky", fail_sticky, e.sticky);
        check("armed", armed, e.armed);
        check("fail_count", fail_count, e.fc);
        check("run_len", run_len, e.rl);
        check("max_run", max_run, e.mr);
        check("first_fail_ts", first_fail_ts, e.ts);
        check("w4.fail_pulse", fail_pulse4, e.pulse);
        check("w4.fail_count", fail_count4, e.fc4);
        check("w4.run_len", run_len4, e.rl4);
        check("w4.max_run", max_run4, e.mr4);
      end
    end
  end

  initial begin
    en = 0; clr = 0; m = 0;
    rst_n = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Violations at cycles 7, 12 and 13 after reset
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, !(i == 7 || i == 12 || i == 13));
    check("ts.fail_count", fail_count, 3);
`ifdef PERSIST_MON_TIMESTAMP_EN
    check("ts.first_fail_ts", first_fail_ts, 7);
`endif

    // Asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    steps(20, 1'b1, 1'b1);
    check("t1.run_len", run_len, 20);
    check("t1.max_run", max_run, 20);
    check("t1.fail_count", fail_count, 0);
    check("t1.fail_sticky", fail_sticky, 0);
    check("t1.armed", armed, 1);
    check("t1.w4.run_len", run_len4, 15);

    step(1'b1, 1'b1, 1'b0);
    check_all_zero("clr1");

    steps(50, 1'b1, 1'b0);
    steps(20, 1'b1, 1'b1);
    check("t2.fail_count", fail_count, 50);
    check("t2.run_len", run_len, 20);
    check("t2.fail_sticky", fail_sticky, 1);
    check("t2.w4.fail_count", fail_count4, 15);

    step(1'b1, 1'b0, 1'b0);
    steps(5, 1'b1, 1'b1);
    check("t3.fail_count", fail_count, 51);
    check("t3.run_len", run_len, 5);
    check("t3.max_run", max_run, 20);

    steps(10, 1'b0, 1'b0);
    check("t4.fail_pulse", fail_pulse, 0);
    check("t4.fail_count", fail_count, 51);
    check("t4.run_len", run_len, 5);
    step(1'b0, 1'b1, 1'b1);
    check_all_zero("clr2");

    steps(20, 1'b1, 1'b0);
    steps(20, 1'b1, 1'b1);
    check("t5.w4.fail_count", fail_count4, 15);
    check("t5.w4.run_len", run_len4, 15);
    check("t5.w4.max_run", max_run4, 15);
    check("t5.fail_count", fail_count, 20);
    check("t5.max_run", max_run, 20);

    step(1'b1, 1'b1, 1'b0);
    steps(3, 1'b1, 1'b1);
    check("t6.run_len", run_len, 3);
    check("t6.fail_sticky", fail_sticky, 0);

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
